tt_sweep_checker: RTL and testbench

//  Sequencer for exhaustive equivalence checking of one optimized N_IN-input, 1-output combinational

---
 rtl/tt_sweep_pkg.sv | 21 ++
 rtl/tt_settle_timer.sv | 26 ++
 rtl/tt_sweep_checker.sv | 163 ++++++++++++++++
 tb/tb_tt_sweep_checker.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_sweep_pkg.sv
// Shared types and sizing for the truth-table sweep checker and its settle timer.
// Sized for the default 5-input netlist; instances derive their own widths from N_IN.
package tt_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      APPLY  = 2'd1,
      SAMPLE = 2'd2,
      FINISH = 2'd3
   } state_t;

   localparam int N_IN_DEF = 5;
   localparam int TT_W     = 2**N_IN_DEF;
   localparam int CNT_W    = N_IN_DEF + 1;

   // The settle counter must hold SETTLE_CYCLES-1. Keep at least one bit so S=0 still elaborates.
   function automatic int settle_w(input int settle_cycles);
      return (settle_cycles < 1) ? 1 : $clog2(settle_cycles + 1);
   endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter. It saturates at zero, and expired is high whenever the count is zero.
module tt_settle_timer #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expired
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - W'(1);
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/tt_sweep_checker.sv
// Exhaustive sweep of a 1-output combinational netlist against a latched golden truth table.
// Every minterm is held for SETTLE_CYCLES cycles and then sampled for one cycle.
module tt_sweep_checker
   import tt_sweep_pkg::*;
#(
   parameter int N_IN          = 5,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [2**N_IN-1:0]   golden_tt,
   output logic [N_IN-1:0]      dut_x,
   input  logic                 dut_y,
   output logic                 busy,
   output logic                 done,
   output logic                 aborted,
   output logic                 pass,
   output logic [N_IN:0]        mismatch_cnt,
   output logic                 first_fail_valid,
   output logic [N_IN-1:0]      first_fail_idx,
   output logic [2**N_IN-1:0]   captured_tt,
   output state_t               fsm_state
);

   localparam int SW = settle_w(SETTLE_CYCLES);

   state_t              state;
   state_t              state_n;
   logic [2**N_IN-1:0]  golden_q;
   logic [N_IN-1:0]     idx;
   logic                timer_load;
   logic                timer_expired;
   logic                last_idx;
   logic                miss;
   logic [N_IN:0]       cnt_next;

   tt_settle_timer #(
      .W (SW)
   ) u_settle (
      .clk      (clk),
      .rst      (rst),
      .load     (timer_load),
      .load_val (SW'(SETTLE_CYCLES - 1)),
      .expired  (timer_expired)
   );

   assign last_idx = (idx == {N_IN{1'b1}});
   assign miss     = (dut_y != golden_q[idx]);
   // The count cannot exceed 2**N_IN, so it cannot wrap.
   assign cnt_next = mismatch_cnt + (N_IN+1)'(miss);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // A load on entry to APPLY makes APPLY last exactly SETTLE_CYCLES cycles.
   always_comb begin
      state_n    = state;
      timer_load = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_n    = APPLY;
               timer_load = 1'b1;
            end
         end
         APPLY: begin
            if (abort) begin
               state_n = IDLE;
            end else if (timer_expired) begin
               state_n = SAMPLE;
            end
         end
         SAMPLE: begin
            if (abort) begin
               state_n = IDLE;
            end else if (last_idx) begin
               state_n = FINISH;
            end else begin
               state_n    = APPLY;
               timer_load = 1'b1;
            end
         end
         FINISH: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         golden_q         <= '0;
         idx              <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         aborted          <= 1'b0;
         pass             <= 1'b0;
         mismatch_cnt     <= '0;
         first_fail_valid <= 1'b0;
         first_fail_idx   <= '0;
         captured_tt      <= '0;
      end else begin
         done    <= 1'b0;
         aborted <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  golden_q         <= golden_tt;
                  idx              <= '0;
                  busy             <= 1'b1;
                  pass             <= 1'b0;
                  mismatch_cnt     <= '0;
                  first_fail_valid <= 1'b0;
                  captured_tt      <= '0;
               end
            end
            APPLY: begin
               if (abort) begin
                  busy    <= 1'b0;
                  aborted <= 1'b1;
                  pass    <= 1'b0;
               end
            end
            SAMPLE: begin
               if (abort) begin
                  busy    <= 1'b0;
                  aborted <= 1'b1;
                  pass    <= 1'b0;
               end else begin
                  captured_tt[idx] <= dut_y;
                  mismatch_cnt     <= cnt_next;
                  if (miss && !first_fail_valid) begin
                     first_fail_valid <= 1'b1;
                     first_fail_idx   <= idx;
                  end
                  if (last_idx) begin
                     busy <= 1'b0;
                     done <= 1'b1;
                     pass <= (cnt_next == '0);
                  end else begin
                     idx <= idx + N_IN'(1);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign dut_x     = idx;
   assign fsm_state = state;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench: an x0 loopback on an S=1 instance and a small gate-level model on an S=3 instance.
module tb_tt_sweep_checker;
   import tt_sweep_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   passed = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // S=1 instance, netlist is y0 = x0
   logic        start1 = 1'b0, abort1 = 1'b0;
   logic [31:0] golden1 = '0;
   logic [4:0]  x1;
   logic        y1, busy1, done1, ab1, pass1, ffv1;
   logic [5:0]  cnt1;
   logic [4:0]  ffi1;
   logic [31:0] cap1;
   state_t      st1;

   // S=3 instance, netlist is a small mixed-gate function
   logic        start3 = 1'b0, abort3 = 1'b0;
   logic [31:0] golden3 = '0;
   logic [4:0]  x3;
   logic        y3, busy3, done3, ab3, pass3, ffv3;
   logic [5:0]  cnt3;
   logic [4:0]  ffi3;
   logic [31:0] cap3;
   state_t      st3;

   function automatic logic model_y(input logic [4:0] x);
      return ((x[0] & x[1]) ^ (x[2] | x[4])) ^ x[3];
   endfunction

   assign y1 = x1[0];
   assign y3 = model_y(x3);

   tt_sweep_checker #(.N_IN(5), .SETTLE_CYCLES(1)) u_s1 (
      .clk(clk), .rst(rst), .start(start1), .abort(abort1), .golden_tt(golden1),
      .dut_x(x1), .dut_y(y1), .busy(busy1), .done(done1), .aborted(ab1), .pass(pass1),
      .mismatch_cnt(cnt1), .first_fail_valid(ffv1), .first_fail_idx(ffi1),
      .captured_tt(cap1), .fsm_state(st1)
   );

   tt_sweep_checker #(.N_IN(5), .SETTLE_CYCLES(3)) u_s3 (
      .clk(clk), .rst(rst), .start(start3), .abort(abort3), .golden_tt(golden3),
      .dut_x(x3), .dut_y(y3), .busy(busy3), .done(done3), .aborted(ab3), .pass(pass3),
      .mismatch_cnt(cnt3), .first_fail_valid(ffv3), .first_fail_idx(ffi3),
      .captured_tt(cap3), .fsm_state(st3)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Start on S=1 during the current cycle, then scramble golden to show the latched copy is used.
   task automatic run_sweep1(input logic [31:0] g, output int lat);
      int k;
      lat     = -1;
      golden1 = g;
      start1  = 1'b1;
      k       = cyc;
      step();
      start1  = 1'b0;
      golden1 = ~g;
      for (int i = 0; i < 400; i++) begin
         if (done1) begin
            lat = cyc - k;
            break;
         end
         step();
      end
   endtask

   task automatic run_sweep3(input logic [31:0] g, output int lat);
      int k;
      lat     = -1;
      golden3 = g;
      start3  = 1'b1;
      k       = cyc;
      step();
      start3  = 1'b0;
      golden3 = ~g;
      for (int i = 0; i < 400; i++) begin
         if (done3) begin
            lat = cyc - k;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      start1 = 1'b1;
      rst    = 1'b1;
      step();
      step();
      checks++;
      if ({x1, busy1, done1, ab1, pass1, cnt1, ffv1, ffi1, cap1} !== '0)
         $display("FAIL reset_s1_outputs got %h exp 0", {x1, busy1, done1, ab1, pass1, cnt1, ffv1, ffi1, cap1});
      else passed++;
      checks++;
      if (st1 !== IDLE) $display("FAIL reset_s1_state got %0d exp %0d", st1, IDLE);
      else passed++;
      checks++;
      if ({x3, busy3, done3, ab3, pass3, cnt3, ffv3, ffi3, cap3} !== '0)
         $display("FAIL reset_s3_outputs got %h exp 0", {x3, busy3, done3, ab3, pass3, cnt3, ffv3, ffi3, cap3});
      else passed++;
      start1 = 1'b0;
      rst    = 1'b0;
      step();
      checks++;
      if (busy1 !== 1'b0) $display("FAIL reset_idle_busy got %b exp 0", busy1);
      else passed++;
   endtask

   task automatic test_loopback_pass();
      int lat;
      run_sweep1(32'hAAAAAAAA, lat);
      checks++;
      if (lat !== 65) $display("FAIL t1_latency got %0d exp 65", lat);
      else passed++;
      checks++;
      if (pass1 !== 1'b1) $display("FAIL t1_pass got %b exp 1", pass1);
      else passed++;
      checks++;
      if (cnt1 !== 6'd0) $display("FAIL t1_cnt got %0d exp 0", cnt1);
      else passed++;
      checks++;
      if (cap1 !== 32'hAAAAAAAA) $display("FAIL t1_captured got %h exp aaaaaaaa", cap1);
      else passed++;
      checks++;
      if ({ffv1, busy1} !== 2'b00) $display("FAIL t1_ffv_busy got %b exp 00", {ffv1, busy1});
      else passed++;
      step();
      checks++;
      if ({done1, st1} !== {1'b0, IDLE}) $display("FAIL t1_done_pulse got done=%b st=%0d exp done=0 st=0", done1, st1);
      else passed++;
      checks++;
      if (pass1 !== 1'b1) $display("FAIL t1_pass_hold got %b exp 1", pass1);
      else passed++;
   endtask

   task automatic test_first_minterm_fail();
      int lat;
      run_sweep1(32'hAAAAAAAB, lat);
      checks++;
      if (lat !== 65) $display("FAIL t2_latency got %0d exp 65", lat);
      else passed++;
      checks++;
      if ({pass1, cnt1, ffv1, ffi1} !== {1'b0, 6'd1, 1'b1, 5'd0})
         $display("FAIL t2_result got pass=%b cnt=%0d ffv=%b ffi=%0d exp pass=0 cnt=1 ffv=1 ffi=0", pass1, cnt1, ffv1, ffi1);
      else passed++;
      step();
   endtask

   task automatic test_last_minterm_fail();
      int lat;
      run_sweep1(32'h2AAAAAAA, lat);
      checks++;
      if (lat !== 65) $display("FAIL t3_latency got %0d exp 65", lat);
      else passed++;
      checks++;
      if ({pass1, cnt1, ffv1, ffi1} !== {1'b0, 6'd1, 1'b1, 5'd31})
         $display("FAIL t3_result got pass=%b cnt=%0d ffv=%b ffi=%0d exp pass=0 cnt=1 ffv=1 ffi=31", pass1, cnt1, ffv1, ffi1);
      else passed++;
      checks++;
      if (cap1 !== 32'hAAAAAAAA) $display("FAIL t3_captured got %h exp aaaaaaaa", cap1);
      else passed++;
      step();
   endtask

   task automatic test_settle3();
      int          lat;
      logic [31:0] gold;
      for (int i = 0; i < 32; i++) gold[i] = model_y(5'(i));
      run_sweep3(gold, lat);
      checks++;
      if (lat !== 129) $display("FAIL t4_latency got %0d exp 129", lat);
      else passed++;
      checks++;
      if ({pass3, cnt3} !== {1'b1, 6'd0}) $display("FAIL t4_pass got pass=%b cnt=%0d exp pass=1 cnt=0", pass3, cnt3);
      else passed++;
      checks++;
      if (cap3 !== gold) $display("FAIL t4_captured got %h exp %h", cap3, gold);
      else passed++;
      step();
      run_sweep3(~gold, lat);
      checks++;
      if (lat !== 129) $display("FAIL t4_inv_latency got %0d exp 129", lat);
      else passed++;
      checks++;
      if ({pass3, cnt3, ffv3, ffi3} !== {1'b0, 6'd32, 1'b1, 5'd0})
         $display("FAIL t4_inv_result got pass=%b cnt=%0d ffv=%b ffi=%0d exp pass=0 cnt=32 ffv=1 ffi=0", pass3, cnt3, ffv3, ffi3);
      else passed++;
      step();
   endtask

   task automatic test_abort();
      int   k;
      int   lat;
      logic seen_done;
      abort1 = 1'b1;
      step();
      abort1 = 1'b0;
      checks++;
      if ({ab1, busy1} !== 2'b00) $display("FAIL t5_idle_abort got ab=%b busy=%b exp 0 0", ab1, busy1);
      else passed++;
      golden1 = 32'hAAAAAAAB;
      start1  = 1'b1;
      k       = cyc;
      step();
      start1  = 1'b0;
      golden1 = '0;
      repeat (20) step();
      checks++;
      if ({x1, st1} !== {5'd10, APPLY}) $display("FAIL t5_at_minterm10 got x=%0d st=%0d exp x=10 st=1", x1, st1);
      else passed++;
      abort1 = 1'b1;
      step();
      abort1 = 1'b0;
      checks++;
      if ({ab1, busy1, done1, pass1, st1} !== {1'b1, 1'b0, 1'b0, 1'b0, IDLE})
         $display("FAIL t5_abort_pulse got ab=%b busy=%b done=%b pass=%b st=%0d exp 1 0 0 0 0", ab1, busy1, done1, pass1, st1);
      else passed++;
      checks++;
      if ({cnt1, cap1} !== {6'd1, 32'h000002AA}) $display("FAIL t5_partial got cnt=%0d cap=%h exp cnt=1 cap=000002aa", cnt1, cap1);
      else passed++;
      seen_done = 1'b0;
      step();
      checks++;
      if (ab1 !== 1'b0) $display("FAIL t5_abort_one_cycle got %b exp 0", ab1);
      else passed++;
      repeat (3) begin
         seen_done = seen_done | done1 | busy1;
         step();
      end
      checks++;
      if (seen_done !== 1'b0) $display("FAIL t5_quiet_after_abort got %b exp 0", seen_done);
      else passed++;
      // start and abort together in IDLE: start wins
      golden1 = 32'hAAAAAAAA;
      start1  = 1'b1;
      abort1  = 1'b1;
      k       = cyc;
      step();
      start1  = 1'b0;
      abort1  = 1'b0;
      checks++;
      if ({busy1, ab1, st1} !== {1'b1, 1'b0, APPLY}) $display("FAIL t5_start_wins got busy=%b ab=%b st=%0d exp 1 0 1", busy1, ab1, st1);
      else passed++;
      lat = -1;
      for (int i = 0; i < 400; i++) begin
         if (done1) begin
            lat = cyc - k;
            break;
         end
         step();
      end
      checks++;
      if (lat !== 65) $display("FAIL t5_restart_latency got %0d exp 65", lat);
      else passed++;
      checks++;
      if ({pass1, cnt1, ffv1, cap1} !== {1'b1, 6'd0, 1'b0, 32'hAAAAAAAA})
         $display("FAIL t5_restart_result got pass=%b cnt=%0d ffv=%b cap=%h exp 1 0 0 aaaaaaaa", pass1, cnt1, ffv1, cap1);
      else passed++;
      step();
   endtask

   task automatic test_back_to_back();
      int k;
      int lat;
      golden1 = 32'hAAAAAAAA;
      start1  = 1'b1;
      k       = cyc;
      step();
      start1  = 1'b0;
      repeat (29) step();
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      lat = -1;
      for (int i = 0; i < 400; i++) begin
         if (done1) begin
            lat = cyc - k;
            break;
         end
         step();
      end
      checks++;
      if (lat !== 65) $display("FAIL t6_repulse_latency got %0d exp 65", lat);
      else passed++;
      // start during the done cycle lands in FINISH and is dropped
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      checks++;
      if ({busy1, st1} !== {1'b0, IDLE}) $display("FAIL t6_start_on_done got busy=%b st=%0d exp 0 0", busy1, st1);
      else passed++;
      checks++;
      if (pass1 !== 1'b1) $display("FAIL t6_pass got %b exp 1", pass1);
      else passed++;
   endtask

   task automatic test_reset_mid_sweep();
      golden1 = 32'hAAAAAAAB;
      start1  = 1'b1;
      step();
      start1  = 1'b0;
      repeat (20) step();
      checks++;
      if ({busy1, cnt1, ffv1} !== {1'b1, 6'd1, 1'b1}) $display("FAIL t6_pre_reset got busy=%b cnt=%0d ffv=%b exp 1 1 1", busy1, cnt1, ffv1);
      else passed++;
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if ({x1, busy1, done1, ab1, pass1, cnt1, ffv1, ffi1, cap1} !== '0)
         $display("FAIL t6_mid_reset got %h exp 0", {x1, busy1, done1, ab1, pass1, cnt1, ffv1, ffi1, cap1});
      else passed++;
      checks++;
      if (st1 !== IDLE) $display("FAIL t6_mid_reset_state got %0d exp 0", st1);
      else passed++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_loopback_pass();
      test_first_minterm_fail();
      test_last_minterm_fail();
      test_settle3();
      test_abort();
      test_back_to_back();
      test_reset_mid_sweep();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
